// File: rtl/frodo_inst_exec.sv
// frodo_inst_exec: Frodo KEM instruction executor sequencing the SHAKE/sampler/multiplier/packer units.
// Optional busy-cycle performance counter is built when FRODO_EXEC_PERF_CNT_EN is defined.
module frodo_inst_exec #(
   parameter int BLK = 8
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_inst_valid,
   input  logic [7:0]  i_pc,
   input  logic [1:0]  i_mode,
   input  logic [1:0]  i_level,
   output logic        o_inst_done,
   output logic        o_inst_err,
   output logic        o_shake_start,
   output logic        o_samp_start,
   output logic        o_mul_start,
   output logic        o_pack_start,
   input  logic        i_shake_done,
   input  logic        i_samp_done,
   input  logic        i_mul_done,
   input  logic        i_pack_done,
   output logic [7:0]  o_unit_row,
   output logic        o_busy,
   output logic [31:0] o_busy_cycles
);
   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ISSUE, S_WAIT, S_DONE} state_t;
   localparam logic [2:0] OP_SHAKE = 3'b000;
   localparam logic [2:0] OP_SAMP  = 3'b001;
   localparam logic [2:0] OP_MULL  = 3'b110;
   localparam logic [2:0] OP_PACK  = 3'b011;
   // Tables are indexed by pc; entries past each table's end are never issued.
   localparam logic [7:0][2:0] KG_TBL = {OP_SHAKE, OP_SHAKE, OP_SHAKE, OP_PACK, OP_MULL, OP_SAMP, OP_SAMP, OP_SHAKE};
   localparam logic [7:0][2:0] EN_TBL = {OP_SHAKE, OP_PACK, OP_SHAKE, OP_PACK, OP_MULL, OP_MULL, OP_SAMP, OP_SHAKE};
   localparam logic [7:0][2:0] DE_TBL = {OP_SHAKE, OP_PACK, OP_MULL, OP_MULL, OP_SAMP, OP_SHAKE, OP_PACK, OP_MULL};
   localparam logic [7:0] ROWS0 = 8'(640 / BLK);
   localparam logic [7:0] ROWS1 = 8'(976 / BLK);
   localparam logic [7:0] ROWS2 = 8'(1344 / BLK);
   state_t          r_state, w_next;
   logic [7:0]      r_pc, r_rows, r_row;
   logic [1:0]      r_mode, r_level, w_unit;
   logic [2:0]      r_op, w_op;
   logic [3:0]      r_start;
   logic            r_err, r_done, r_inst_err, r_busy;
   logic [7:0][2:0] w_tbl;
   logic [7:0]      w_lim, w_rows;
   logic            w_ill, w_sel_done, w_last;
   always_comb begin
      w_tbl      = (r_mode == 2'd0) ? KG_TBL : (r_mode == 2'd1) ? EN_TBL : DE_TBL;
      w_lim      = (r_mode == 2'd0) ? 8'd5 : (r_mode == 2'd1) ? 8'd6 : 8'd7;
      w_ill      = (r_mode == 2'd3) || (r_level == 2'd3) || (r_pc > w_lim);
      w_op       = w_tbl[r_pc[2:0]];
      w_rows     = (r_level == 2'd0) ? ROWS0 : (r_level == 2'd1) ? ROWS1 : ROWS2;
      w_sel_done = (r_op[1:0] == 2'd0) ? i_shake_done : (r_op[1:0] == 2'd1) ? i_samp_done :
                   (r_op[1:0] == 2'd2) ? i_mul_done : i_pack_done;
      w_last     = !(r_op[2] && (r_row < r_rows - 8'd1));
      w_unit     = (r_state == S_DECODE) ? w_op[1:0] : r_op[1:0];
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = i_inst_valid ? S_DECODE : S_IDLE;
         S_DECODE: w_next = w_ill ? S_DONE : S_ISSUE;
         S_ISSUE:  w_next = S_WAIT;
         S_WAIT:   w_next = w_sel_done ? (w_last ? S_DONE : S_ISSUE) : S_WAIT;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (!i_rstn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end
   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_pc       <= '0;
         r_mode     <= '0;
         r_level    <= '0;
         r_op       <= '0;
         r_rows     <= '0;
         r_row      <= '0;
         r_err      <= 1'b0;
         r_start    <= '0;
         r_done     <= 1'b0;
         r_inst_err <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         if (r_state == S_IDLE && i_inst_valid) begin
            r_pc    <= i_pc;
            r_mode  <= i_mode;
            r_level <= i_level;
            r_row   <= '0;
         end
         if (r_state == S_DECODE) begin
            r_op   <= w_op;
            r_rows <= w_rows;
            r_err  <= w_ill;
         end
         if (r_state == S_WAIT && w_sel_done && !w_last) r_row <= r_row + 8'd1;
         if (r_state == S_DONE) r_err <= 1'b0;
         r_start    <= (w_next == S_ISSUE) ? 4'(4'b1 << w_unit) : 4'b0;
         r_done     <= (w_next == S_DONE);
         r_inst_err <= (w_next == S_DONE) && ((r_state == S_DECODE) ? w_ill : r_err);
         r_busy     <= (w_next != S_IDLE);
      end
   end
   assign o_inst_done   = r_done;
   assign o_inst_err    = r_inst_err;
   assign o_shake_start = r_start[0];
   assign o_samp_start  = r_start[1];
   assign o_mul_start   = r_start[2];
   assign o_pack_start  = r_start[3];
   assign o_unit_row    = r_row;
   assign o_busy        = r_busy;
`ifdef FRODO_EXEC_PERF_CNT_EN
   logic [31:0] r_cnt;
   always_ff @(posedge i_clk) begin
      if (!i_rstn)                            r_cnt <= '0;
      else if (r_busy && r_cnt != '1)         r_cnt <= r_cnt + 32'd1;
   end
   assign o_busy_cycles = r_cnt;
`else
   assign o_busy_cycles = '0;
`endif
endmodule

// File: tb/tb_frodo_inst_exec.sv
// tb_frodo_inst_exec: directed and randomized instructions checked against a table-driven
// model of the instruction sequence, with unit responders of random latency.
module tb_frodo_inst_exec;
   logic        clk = 1'b0, rstn = 1'b0, valid = 1'b0;
   logic [7:0]  pc = '0;
   logic [1:0]  mode = '0, level = '0;
   logic [3:0]  dn = '0;
   logic        inst_done, inst_err, busy;
   logic [3:0]  st;
   logic [7:0]  row;
   logic [31:0] bcyc;
   int          ncmp = 0, nfail = 0;
   int          busy_tot = 0;
   int          kg[$] = '{0, 1, 1, 2, 3, 0};
   int          en[$] = '{0, 1, 2, 2, 3, 0, 3};
   int          de[$] = '{2, 3, 0, 1, 2, 2, 3, 0};
   int          nval[3] = '{640, 976, 1344};

   frodo_inst_exec #(.BLK(8)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_inst_valid(valid), .i_pc(pc), .i_mode(mode), .i_level(level),
      .o_inst_done(inst_done), .o_inst_err(inst_err),
      .o_shake_start(st[0]), .o_samp_start(st[1]), .o_mul_start(st[2]), .o_pack_start(st[3]),
      .i_shake_done(dn[0]), .i_samp_done(dn[1]), .i_mul_done(dn[2]), .i_pack_done(dn[3]),
      .o_unit_row(row), .o_busy(busy), .o_busy_cycles(bcyc));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int tbl_size(int m);
      return (m == 0) ? kg.size() : (m == 1) ? en.size() : de.size();
   endfunction

   function automatic int op_unit(int m, int p);
      return (m == 0) ? kg[p] : (m == 1) ? en[p] : de[p];
   endfunction

   task automatic chk_perf(input string tag);
`ifdef FRODO_EXEC_PERF_CNT_EN
      chk(tag, bcyc, busy_tot);
`else
      chk(tag, bcyc, 0);
`endif
   endtask

   // One instruction: the model predicts each start and the retire cycle from the unit
   // tables and the responder's chosen latencies; every cycle is compared.
   task automatic run(input int m, input int l, input int p, input int fixlat, input bit noise);
      int c, exp_evt, remaining, iter, done_at, unit, lat;
      bit ill, fin, exp_done;
      logic [3:0] exp_st;
      ill       = (m == 3) || (l == 3) || (p >= tbl_size(m));
      unit      = ill ? 0 : op_unit(m, p);
      remaining = ill ? 0 : ((unit == 2) ? nval[l] / 8 : 1);
      @(negedge clk);
      valid = 1'b1; pc = 8'(p); mode = 2'(m); level = 2'(l); dn = '0;
      c = 0; exp_evt = 2; iter = 0; done_at = -1; fin = 1'b0;
      while (!fin) begin
         @(negedge clk);
         c++;
         exp_st = (c == exp_evt && remaining > 0) ? 4'(1 << unit) : 4'b0;
         chk("start", st, exp_st);
         chk("busy", busy, 1);
         if (exp_st != 0) begin
            chk("row_at_start", row, iter);
            lat = (fixlat > 0) ? fixlat : $urandom_range(1, 4);
            done_at = c + lat;
            exp_evt = c + lat + 1;
            remaining--;
            iter++;
         end
         exp_done = (c == exp_evt) && (remaining == 0) && (exp_st == 0);
         chk("inst_done", inst_done, exp_done);
         chk("inst_err", inst_err, exp_done && ill);
         if (exp_done) begin
            chk("row_at_done", row, (iter > 0) ? iter - 1 : 0);
            fin = 1'b1;
         end
         dn = '0;
         valid = 1'b0;
         if (!fin) begin
            if (c == done_at) dn[unit] = 1'b1;
            if (noise) begin
               for (int u = 0; u < 4; u++) if (u != unit) dn[u] = 1'($urandom_range(0, 1));
               if (exp_st != 0 && !ill) dn[unit] = 1'b1;
               valid = 1'($urandom_range(0, 1));
               pc    = 8'($urandom_range(0, 9));
               mode  = 2'($urandom_range(0, 3));
               level = 2'($urandom_range(0, 3));
            end
         end
      end
      busy_tot += c;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", inst_done, 0);
      chk("idle_start", st, 0);
      chk_perf("busy_cycles");
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_done", inst_done, 0);
      chk("rst_err", inst_err, 0);
      chk("rst_start", st, 0);
      chk("rst_row", row, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bcyc", bcyc, 0);
      rstn = 1'b1;
      run(0, 0, 0, 5, 1'b0);
`ifdef FRODO_EXEC_PERF_CNT_EN
      chk("perf_keygen", bcyc, 8);
`else
      chk("perf_keygen", bcyc, 0);
`endif
      run(1, 1, 2, 3, 1'b0);
      run(2, 0, 8, 0, 1'b0);
      run(3, 0, 0, 0, 1'b0);
      run(0, 3, 0, 0, 1'b0);
      run(0, 0, 6, 0, 1'b0);
      run(2, 0, 0, 0, 1'b1);
      run(0, 1, 1, 2, 1'b1);
      // Reset while the multiplier is in flight, then a stale done must be ignored.
      @(negedge clk);
      valid = 1'b1; mode = 2'd1; level = 2'd0; pc = 8'd2;
      @(negedge clk);
      valid = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("midrst_done", inst_done, 0);
         chk("midrst_err", inst_err, 0);
         chk("midrst_start", st, 0);
         chk("midrst_row", row, 0);
         chk("midrst_busy", busy, 0);
         chk("midrst_bcyc", bcyc, 0);
      end
      rstn = 1'b1;
      busy_tot = 0;
      dn[2] = 1'b1;
      @(negedge clk);
      dn = '0;
      repeat (6) begin
         @(negedge clk);
         chk("stale_done", inst_done, 0);
         chk("stale_busy", busy, 0);
         chk("stale_start", st, 0);
      end
      for (int k = 0; k < 30; k++)
         run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), 0,
             1'($urandom_range(0, 1)));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule

// File: doc/frodo_inst_exec.md
# frodo_inst_exec

Instruction executor for the Frodo KEM datapath. It is the responder side of the controller's `inst_valid` / `inst_done` handshake. It captures the program counter, mode and security level, and decodes them through a fixed per-mode instruction table. It then sequences start/done handshakes with the four datapath units (SHAKE, sampler, matrix multiplier, packer) and returns a single-cycle `inst_done` when the instruction has fully retired.

## Interface
Parameters:
- `BLK`, default 8: rows per multiplier invocation; loop count = n/BLK, with n = 640/976/1344 for level 0/1/2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rstn`  in  1  reset; synchronous, active-low.
- `inst_valid`  in  1  one-cycle request from the controller.
- `pc`  in  8  instruction index; sampled with `inst_valid`.
- `mode`  in  2  0 KEYGEN, 1 ENCAP, 2 DECAP, 3 illegal; sampled with `inst_valid`.
- `level`  in  2  0/1/2 legal, 3 illegal; sampled with `inst_valid`.
- `inst_done`  out  1  one-cycle retire pulse.
- `inst_err`  out  1  one-cycle pulse coincident with `inst_done` for an illegal request.
- `shake_start`, `samp_start`, `mul_start`, `pack_start`  out  1 each  one-cycle unit start pulses.
- `shake_done`, `samp_done`, `mul_done`, `pack_done`  in  1 each  unit completion pulses.
- `unit_row`  out  8  current loop iteration; 0 for non-loop instructions.
- `busy`  out  1  high in every state except IDLE.
- `busy_cycles`  out  32  performance counter (see Configuration).

## Operation
- Opcode format: {loop, unit[1:0]}. Unit 0 is SHAKE, 1 is SAMP, 2 is MUL, 3 is PACK. Only MUL opcodes set loop.
- KEYGEN table, pc 0–5: SHAKE, SAMP, SAMP, MUL-loop, PACK, SHAKE.
- ENCAP table, pc 0–6: SHAKE, SAMP, MUL-loop, MUL-loop, PACK, SHAKE, PACK.
- DECAP table, pc 0–7: MUL-loop, PACK, SHAKE, SAMP, MUL-loop, MUL-loop, PACK, SHAKE.
- A request is illegal if mode = 3, level = 3, or pc is beyond the table for the mode.
- rows = n/BLK, giving 80/122/168 at the default BLK.
- FSM states: IDLE, DECODE, ISSUE, WAIT, DONE.
- IDLE: on `inst_valid`, register pc/mode/level, clear `unit_row`, go to DECODE.
- DECODE: register the opcode and rows. If illegal, go to DONE with the error flag set; otherwise go to ISSUE.
- ISSUE: pulse the selected unit's start for 1 cycle, then go to WAIT.
- WAIT:
  - Only the selected unit's done is observed; other done inputs are ignored.
  - On done, if loop && `unit_row` < rows−1: increment `unit_row` and go to ISSUE.
  - Otherwise go to DONE.
- DONE: pulse `inst_done` (and `inst_err` if the error flag is set), clear the error flag, return to IDLE.
- `inst_valid` in any state other than IDLE is ignored; there is no queueing.
- A done pulse arriving during ISSUE, i.e. in the same cycle as start, is not seen. Units must respond ≥1 cycle after start.
- `unit_row` is 8 bits wide; the maximum value 167 never wraps.
- Reset mid-operation: FSM returns to IDLE and all outputs go to 0 on the next edge. An in-flight unit done after reset is ignored.

## Timing
- Reset values: `inst_done`, `inst_err`, all `*_start`, `unit_row`, `busy` and `busy_cycles` are all 0.
- All outputs are registered.
- `inst_valid` sampled at edge T: DECODE is at T+1 and start is high in cycle T+2.
- Unit done sampled at edge D (last iteration): `inst_done` is high in cycle D+1, and IDLE is reached at D+2.
- Looping: done at edge D brings the next start in cycle D+1. Per-iteration overhead is 1 cycle beyond unit latency.
- Illegal request: `inst_done` and `inst_err` are high in cycle T+2. No start is issued.
- Minimum legal instruction with a unit latency of 1 cycle: `inst_done` is 4 cycles after `inst_valid`.

## Configuration
- `FRODO_EXEC_PERF_CNT_EN` defined:
  - `busy_cycles` increments by 1 every cycle `busy` is high.
  - It saturates at 0xFFFF_FFFF and is cleared only by reset.
- `FRODO_EXEC_PERF_CNT_EN` undefined: no counter logic is built and `busy_cycles` is constant 0.

## Test plan
- Reset: hold `rstn`=0 for 2 cycles during WAIT. Require all outputs = 0; a `mul_done` pulse afterwards produces no `inst_done`.
- KEYGEN pc=0, level 0, `shake_done` 5 cycles after `shake_start`. Require exactly one `shake_start`, `inst_done` 1 cycle after done, and `unit_row`=0.
- ENCAP pc=2, level 1, BLK=8, `mul_done` 3 cycles after each start. Require 122 `mul_start` pulses, last `unit_row`=121, and a single `inst_done`.
- DECAP pc=8, mode=3, and level=3, each requested in turn. Require `inst_done`=`inst_err`=1 in cycle T+2 and no start pulse.
- WAIT on MUL while `shake_done`/`pack_done` pulse and `inst_valid` is re-asserted. Require no effect until `mul_done`.
- With `FRODO_EXEC_PERF_CNT_EN`: run KEYGEN pc=0 with a 5-cycle unit latency. Require `busy_cycles` = busy-high duration (8). Without the macro, require `busy_cycles` stays 0.
